mips32_boot_loader: RTL and testbench



---
 rtl/mips32_boot_loader.sv | 134 +++++++++++++
 tb/tb_mips32_boot_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mips32_boot_loader.sv
// Boot/run controller for the pipelined MIPS32 core: streams a program into core memory,
// releases the core, times the run and reports halt, overflow or watchdog expiry.
module mips32_boot_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024,
    parameter int TIMEOUT   = 100000
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    input  logic              clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst_n,
    input  logic              core_halted,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       run_cycles
);

    // state | meaning
    // IDLE  | waiting for first program word, core held in reset
    // LOAD  | accepting further words, core held in reset
    // RUN   | core released one cycle after entry, run cycles counted
    // DONE  | core halted normally, core left out of reset for readback
    // ERR   | overflow or watchdog expiry, core held in reset
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DONE, S_ERR} state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MAX_WORDS - 1);
    localparam logic [31:0]     TO_LAST  = 32'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              we_d, crst_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d, rc_d;
    logic [ADDR_W:0]   wc_d;
    logic              accept;

    assign s_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign busy    = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign err     = (state_q == S_ERR);
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rst_n <= 1'b0;
            word_count <= '0;
            run_cycles <= '0;
        end else begin
            state_q    <= state_d;
            mem_we     <= we_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            core_rst_n <= crst_d;
            word_count <= wc_d;
            run_cycles <= rc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        crst_d  = core_rst_n;
        wc_d    = word_count;
        rc_d    = run_cycles;

        if (accept) begin
            we_d    = 1'b1;
            addr_d  = word_count[ADDR_W-1:0];
            wdata_d = s_data;
            wc_d    = word_count + 1'b1;
        end

        case (state_q)
            S_IDLE, S_LOAD: begin
                crst_d = 1'b0;
                if (accept) begin
                    if (s_last)
                        state_d = S_RUN;
                    else if (word_count == LAST_IDX)
                        state_d = S_ERR;
                    else
                        state_d = S_LOAD;
                end
            end
            S_RUN: begin
                // release lags RUN entry by one edge so the last write lands first
                crst_d = 1'b1;
                if (core_rst_n) begin
                    if (core_halted) begin
                        state_d = S_DONE;
                    end else begin
                        rc_d = run_cycles + 32'd1;
                        if (run_cycles == TO_LAST) begin
                            state_d = S_ERR;
                            crst_d  = 1'b0;
                        end
                    end
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_d = S_IDLE;
                    crst_d  = 1'b0;
                    wc_d    = '0;
                    rc_d    = '0;
                end
            end
            S_ERR: begin
                crst_d = 1'b0;
                if (clear) begin
                    state_d = S_IDLE;
                    wc_d    = '0;
                    rc_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips32_boot_loader.sv
// Directed bench for mips32_boot_loader; a second instance with MAX_WORDS=4 covers overflow.
module tb_mips32_boot_loader;

    logic        clk1 = 1'b0;
    logic        rst_n, s_valid, s_last, clear, core_halted, sel;
    logic [31:0] s_data;

    logic        a_ready, a_we, a_crst, a_busy, a_done, a_err;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata, a_rc;
    logic [10:0] a_wc;
    logic        b_ready, b_we, b_crst, b_busy, b_done, b_err;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata, b_rc;
    logic [10:0] b_wc;

    logic        s_ready, mem_we, core_rst_n, busy, done, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, run_cycles;
    logic [10:0] word_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk1 = ~clk1;

    mips32_boot_loader #(.ADDR_W(10), .MAX_WORDS(1024), .TIMEOUT(50)) dut (
        .clk1(clk1), .rst_n(rst_n), .s_valid(s_valid & ~sel), .s_ready(a_ready),
        .s_data(s_data), .s_last(s_last), .clear(clear & ~sel), .mem_we(a_we),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .core_rst_n(a_crst),
        .core_halted(core_halted), .busy(a_busy), .done(a_done), .err(a_err),
        .word_count(a_wc), .run_cycles(a_rc));

    mips32_boot_loader #(.ADDR_W(10), .MAX_WORDS(4), .TIMEOUT(50)) dut_ovf (
        .clk1(clk1), .rst_n(rst_n), .s_valid(s_valid & sel), .s_ready(b_ready),
        .s_data(s_data), .s_last(s_last), .clear(clear & sel), .mem_we(b_we),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .core_rst_n(b_crst),
        .core_halted(core_halted), .busy(b_busy), .done(b_done), .err(b_err),
        .word_count(b_wc), .run_cycles(b_rc));

    assign s_ready    = sel ? b_ready : a_ready;
    assign mem_we     = sel ? b_we    : a_we;
    assign mem_addr   = sel ? b_addr  : a_addr;
    assign mem_wdata  = sel ? b_wdata : a_wdata;
    assign core_rst_n = sel ? b_crst  : a_crst;
    assign busy       = sel ? b_busy  : a_busy;
    assign done       = sel ? b_done  : a_done;
    assign err        = sel ? b_err   : a_err;
    assign word_count = sel ? b_wc    : a_wc;
    assign run_cycles = sel ? b_rc    : a_rc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                              32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                              32'hfc000000};

    initial begin
        int n;
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; clear = 1'b0;
        core_halted = 1'b0; sel = 1'b0; s_data = '0;
        #2;
        chk("rst_ready", s_ready, 1); chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
        chk("rst_crst", core_rst_n, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_err", err, 0);
        chk("rst_wc", word_count, 0); chk("rst_rc", run_cycles, 0);
        @(negedge clk1) rst_n = 1'b1;

        // basic back-to-back load
        s_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            s_data = prog[i]; s_last = (i == 8);
            step();
            chk("load_we", mem_we, 1); chk("load_addr", mem_addr, i);
            chk("load_data", mem_wdata, prog[i]); chk("load_wc", word_count, i + 1);
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("load_crst_e1", core_rst_n, 0); chk("load_busy", busy, 1);
        chk("run_ready", s_ready, 0);
        step();
        chk("load_crst_e2", core_rst_n, 1); chk("run_we0", mem_we, 0);

        // run to halt, sender pushing during RUN
        s_valid = 1'b1; s_data = 32'hdeadbeef;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("run_no_we", mem_we, 0); chk("run_no_ready", s_ready, 0);
        end
        chk("run_rc12", run_cycles, 12); chk("run_not_done", done, 0);
        chk("run_wc", word_count, 9);
        core_halted = 1'b1;
        step();
        chk("halt_done", done, 1); chk("halt_rc", run_cycles, 12);
        chk("halt_crst", core_rst_n, 1); chk("halt_err", err, 0); chk("halt_busy", busy, 0);
        step();
        chk("done_rc_frozen", run_cycles, 12); chk("done_no_we", mem_we, 0);

        // clear together with s_valid: only the return to IDLE
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_done", done, 0); chk("clr_wc", word_count, 0); chk("clr_rc", run_cycles, 0);
        chk("clr_crst", core_rst_n, 0); chk("clr_no_we", mem_we, 0); chk("clr_ready", s_ready, 1);
        step();
        chk("post_clr_we", mem_we, 1); chk("post_clr_addr", mem_addr, 0);
        chk("post_clr_data", mem_wdata, 32'hdeadbeef); chk("post_clr_wc", word_count, 1);

        // gapped load with stale HALTED still high
        for (int i = 1; i < 3; i++) begin
            s_valid = 1'b0;
            repeat ($urandom_range(3, 1)) begin
                step();
                chk("gap_no_we", mem_we, 0);
            end
            s_valid = 1'b1; s_data = prog[i]; s_last = (i == 2);
            step();
            chk("gap_we", mem_we, 1); chk("gap_addr", mem_addr, i);
            chk("gap_data", mem_wdata, prog[i]); chk("gap_wc", word_count, i + 1);
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("stale_crst0", core_rst_n, 0);
        step();
        chk("stale_crst1", core_rst_n, 1); chk("stale_ignored", done, 0);
        step();
        chk("stale_done", done, 1); chk("stale_rc", run_cycles, 0);
        core_halted = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;

        // watchdog with a single-word program
        s_valid = 1'b1; s_data = prog[8]; s_last = 1'b1;
        step();
        s_valid = 1'b0; s_last = 1'b0;
        chk("wd_wc", word_count, 1); chk("wd_busy", busy, 1);
        step();
        chk("wd_crst", core_rst_n, 1);
        n = 0;
        while (!err && n < 200) begin
            step();
            n++;
        end
        chk("wd_cycles", n, 50); chk("wd_err", err, 1); chk("wd_rc", run_cycles, 50);
        chk("wd_crst_low", core_rst_n, 0); chk("wd_done", done, 0);
        step();
        chk("wd_rc_frozen", run_cycles, 50);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("wd_clr_err", err, 0); chk("wd_clr_rc", run_cycles, 0);
        chk("wd_clr_wc", word_count, 0); chk("wd_clr_crst", core_rst_n, 0);
        chk("wd_clr_ready", s_ready, 1);

        // overflow on the MAX_WORDS=4 instance
        sel = 1'b1; s_valid = 1'b1; s_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_data = prog[i];
            step();
            chk("ovf_we", mem_we, 1); chk("ovf_addr", mem_addr, i);
            chk("ovf_data", mem_wdata, prog[i]);
        end
        chk("ovf_err", err, 1); chk("ovf_ready", s_ready, 0);
        chk("ovf_crst", core_rst_n, 0); chk("ovf_wc", word_count, 4);
        s_data = prog[4];
        step();
        chk("ovf_5th_we", mem_we, 0); chk("ovf_5th_wc", word_count, 4); chk("ovf_err_hold", err, 1);
        s_valid = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0; sel = 1'b0;

        // asynchronous reset in the middle of a load
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = prog[i + 3];
            step();
        end
        s_valid = 1'b0;
        chk("mid_addr_pre", mem_addr, 2); chk("mid_wc_pre", word_count, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wc", word_count, 0); chk("arst_we", mem_we, 0);
        chk("arst_addr", mem_addr, 0); chk("arst_wdata", mem_wdata, 0);
        chk("arst_busy", busy, 0); chk("arst_ready", s_ready, 1);
        @(negedge clk1) rst_n = 1'b1;
        s_valid = 1'b1; s_data = prog[5]; s_last = 1'b1;
        step();
        s_valid = 1'b0; s_last = 1'b0;
        chk("fresh_we", mem_we, 1); chk("fresh_addr", mem_addr, 0);
        chk("fresh_data", mem_wdata, prog[5]); chk("fresh_wc", word_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
